// File: rtl/regs_debug_serializer_pkg.sv
// -----------------------------------------------------------------------------
// regs_debug_serializer_pkg
//   Shared definitions for the register-bank debug serializer:
//   - default values for the three size parameters,
//   - the FSM state encoding (IDLE=00, SEND=01, DONE=10),
//   - a helper that derives the number of output bytes per register.
// -----------------------------------------------------------------------------
package regs_debug_serializer_pkg;

    localparam int DEFAULT_REGISTERS_BANK_SIZE = 32;
    localparam int DEFAULT_BUS_SIZE            = 32;
    localparam int DEFAULT_BYTE_SIZE           = 8;

    typedef enum logic [1:0] {
        RDS_IDLE = 2'b00,
        RDS_SEND = 2'b01,
        RDS_DONE = 2'b10
    } rds_state_t;

    function automatic int bytes_per_reg(input int bus_size, input int byte_size);
        return bus_size / byte_size;
    endfunction

endpackage

// File: rtl/regs_debug_serializer_mux.sv
// -----------------------------------------------------------------------------
// mux
//   Generic N-channel word selector. Channel c occupies
//   i_data[c*BUS_SIZE +: BUS_SIZE]; o_data presents the channel chosen by i_sel.
//   An out-of-range select yields zero.
// Ports
//   i_data  in   CHANNELS*BUS_SIZE  packed channels, channel 0 at the LSBs
//   i_sel   in   SEL_W              channel index
//   o_data  out  BUS_SIZE           selected channel
// -----------------------------------------------------------------------------
module mux #(
    parameter int CHANNELS = 4,
    parameter int BUS_SIZE = 8,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS*BUS_SIZE-1:0] i_data,
    input  logic [SEL_W-1:0]             i_sel,
    output logic [BUS_SIZE-1:0]          o_data
);

    always_comb begin
        o_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_sel == SEL_W'(c)) begin
                o_data = i_data[c*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

endmodule

// File: rtl/regs_debug_serializer.sv
// -----------------------------------------------------------------------------
// regs_debug_serializer
//   Consumer end of the register-bank debug bus. A start pulse snapshots the
//   whole flat register bus; the snapshot is then streamed one byte per
//   valid/ready handshake, register 0 first, MSB byte first within a register.
// Ports
//   i_clk        in   1                      clock, rising edge
//   i_reset      in   1                      synchronous reset, active-low
//   i_start      in   1                      one-cycle dump request (IDLE only)
//   i_bus_debug  in   BANK*BUS_SIZE          register k at [k*BUS_SIZE +: BUS_SIZE]
//   i_tx_ready   in   1                      downstream accepts o_tx_data
//   o_tx_data    out  BYTE_SIZE              byte on offer (combinational)
//   o_tx_valid   out  1                      o_tx_data valid
//   o_busy       out  1                      dump in progress
//   o_done       out  1                      one-cycle pulse after last byte
//   o_reg_idx    out  $clog2(BANK)           register currently being sent
// -----------------------------------------------------------------------------
module regs_debug_serializer
    import regs_debug_serializer_pkg::*;
#(
    parameter int REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
    parameter int BUS_SIZE            = DEFAULT_BUS_SIZE,
    parameter int BYTE_SIZE           = DEFAULT_BYTE_SIZE
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_start,
    input  logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] i_bus_debug,
    input  logic                                    i_tx_ready,
    output logic [BYTE_SIZE-1:0]                    o_tx_data,
    output logic                                    o_tx_valid,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic [$clog2(REGISTERS_BANK_SIZE)-1:0]  o_reg_idx
);

    localparam int BYTES_PER_REG = bytes_per_reg(BUS_SIZE, BYTE_SIZE);
    localparam int REG_IDX_W     = $clog2(REGISTERS_BANK_SIZE);
    localparam int BYTE_IDX_W    = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

    localparam logic [REG_IDX_W-1:0]  LAST_REG  = REG_IDX_W'(REGISTERS_BANK_SIZE - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_REG - 1);

    rds_state_t                              state;
    logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] snapshot;
    logic [REG_IDX_W-1:0]                    reg_idx;
    logic [BYTE_IDX_W-1:0]                   byte_idx;

    logic [BUS_SIZE-1:0]                     cur_reg;
    logic [BYTE_IDX_W-1:0]                   byte_sel;

    assign cur_reg   = snapshot[int'(reg_idx)*BUS_SIZE +: BUS_SIZE];
    // The mux places channel 0 at the LSBs, so byte 0 (the MSB byte) is the
    // highest channel.
    assign byte_sel  = LAST_BYTE - byte_idx;
    assign o_reg_idx = reg_idx;

    mux #(
        .CHANNELS (BYTES_PER_REG),
        .BUS_SIZE (BYTE_SIZE),
        .SEL_W    (BYTE_IDX_W)
    ) u_byte_mux (
        .i_data (cur_reg),
        .i_sel  (byte_sel),
        .o_data (o_tx_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= RDS_IDLE;
            snapshot   <= '0;
            reg_idx    <= '0;
            byte_idx   <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                RDS_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        snapshot   <= i_bus_debug;
                        reg_idx    <= '0;
                        byte_idx   <= '0;
                        o_tx_valid <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= RDS_SEND;
                    end
                end
                RDS_SEND: begin
                    if (o_tx_valid && i_tx_ready) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + BYTE_IDX_W'(1);
                        end else begin
                            byte_idx <= '0;
                            if (reg_idx == LAST_REG) begin
                                // Last byte accepted: park the index at 0
                                // rather than letting it overflow.
                                reg_idx    <= '0;
                                o_tx_valid <= 1'b0;
                                o_busy     <= 1'b0;
                                o_done     <= 1'b1;
                                state      <= RDS_DONE;
                            end else begin
                                reg_idx <= reg_idx + REG_IDX_W'(1);
                            end
                        end
                    end
                end
                RDS_DONE: begin
                    o_done <= 1'b0;
                    state  <= RDS_IDLE;
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                    state      <= RDS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_debug_serializer.sv
// -----------------------------------------------------------------------------
// tb_regs_debug_serializer
//   Scoreboard bench: expected bytes are queued when a dump is started and
//   compared against the bytes captured on completed handshakes.
// -----------------------------------------------------------------------------
module tb_regs_debug_serializer;

    localparam int NREG   = 32;
    localparam int BW     = 32;
    localparam int BYW    = 8;
    localparam int NBYTES = 128;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                tx_ready = 1'b0;
    logic [NREG*BW-1:0]  bus_debug = '0;
    logic [BYW-1:0]      tx_data;
    logic                tx_valid;
    logic                busy;
    logic                done;
    logic [4:0]          reg_idx;

    always #5 clk = ~clk;

    regs_debug_serializer #(
        .REGISTERS_BANK_SIZE (NREG),
        .BUS_SIZE            (BW),
        .BYTE_SIZE           (BYW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_bus_debug (bus_debug),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_reg_idx   (reg_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int   done_cnt    = 0;
    int   cyc         = 0;
    int   last_hs_cyc = -1;
    int   done_cyc    = -1;
    int   stab_err    = 0;
    int   valid_gap   = 0;
    int   stall_left  = 0;
    logic prev_stall  = 1'b0;
    logic [7:0] prev_data = '0;

    // Capture monitor: values seen at the falling edge are the ones the next
    // rising edge samples.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall && tx_valid && (tx_data !== prev_data)) stab_err++;
        if (rst_n && busy && !tx_valid) valid_gap++;
        prev_stall = rst_n && tx_valid && !tx_ready;
        prev_data  = tx_data;
        cyc++;
    end

    task automatic set_pattern(input int mode);
        for (int k = 0; k < NREG; k++) begin
            case (mode)
                0:       bus_debug[k*BW +: BW] = 32'hA500_0000 | 32'(k);
                1:       bus_debug[k*BW +: BW] = (32'(k) * 32'h0101_0101) ^ 32'h1234_5678;
                default: bus_debug[k*BW +: BW] = 32'hFFFF_FFFF;
            endcase
        end
    endtask

    task automatic push_expected();
        for (int k = 0; k < NREG; k++)
            for (int b = 0; b < BW/BYW; b++)
                exp_q.push_back(bus_debug[k*BW + BW-1 - b*BYW -: BYW]);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic pulse_start(input bit push);
        @(posedge clk); #1;
        start = 1'b1;
        if (push) push_expected();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives i_tx_ready each cycle until o_done is observed or the budget runs out.
    // mode 0: ready held high; mode 1: random ready with 5-cycle stalls.
    task automatic run_until_done(input int max_cycles, input int mode, input int start_at,
                                  output bit timed_out);
        int d0;
        bit pulsed;
        d0 = done_cnt;
        pulsed = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
            if (!pulsed && start_at >= 0 && got_q.size() == start_at) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (mode == 0) begin
                tx_ready = 1'b1;
            end else if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                tx_ready = 1'b0;
                stall_left = 4;
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (reg_idx !== 5'd0)  begin n_fail++; $display("FAIL reset_reg_idx got %0d want 0", reg_idx); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tx_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency_and_full();
        bit to;
        int d0;
        set_pattern(0);
        clear_sb();
        tx_ready = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b1);
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", tx_valid); end
        n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL lat_data got %h want a5", tx_data); end
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL lat_busy got %b want 1", busy); end
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL hold_data got %h want a5", tx_data); end
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL hold_busy got %b want 1", busy); end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL hold_no_hs got %0d want 0", got_q.size()); end
        tx_ready = 1'b1;
        run_until_done(400, 0, -1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL full_timeout got timeout want done"); end
        n_tests++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL full_count got %0d want %0d", got_q.size(), NBYTES); end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL full_byte%0d got %h want %h", i, g, e); end
        end
        n_tests++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL done_timing got cyc %0d want %0d", done_cyc, last_hs_cyc + 1); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_done_pulses got %0d want 1", done_cnt - d0); end
        n_tests++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL full_idle_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_backpressure();
        bit to;
        int d0, s0, v0;
        set_pattern(0);
        clear_sb();
        d0 = done_cnt; s0 = stab_err; v0 = valid_gap;
        stall_left = 0;
        tx_ready = 1'b0;
        pulse_start(1'b1);
        run_until_done(4000, 1, -1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
        n_tests++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), NBYTES); end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, g, e); end
        end
        n_tests++; if (stab_err != s0)  begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stab_err - s0); end
        n_tests++; if (valid_gap != v0) begin n_fail++; $display("FAIL bp_valid_gap got %0d want 0", valid_gap - v0); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_snapshot();
        bit to;
        set_pattern(1);
        clear_sb();
        tx_ready = 1'b1;
        pulse_start(1'b1);
        set_pattern(2);
        run_until_done(400, 0, -1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL snap_timeout got timeout want done"); end
        n_tests++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL snap_count got %0d want %0d", got_q.size(), NBYTES); end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL snap_byte%0d got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        int d0;
        set_pattern(0);
        clear_sb();
        d0 = done_cnt;
        tx_ready = 1'b1;
        pulse_start(1'b1);
        set_pattern(1);
        run_until_done(400, 0, 50, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL busy_timeout got timeout want done"); end
        n_tests++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL busy_count got %0d want %0d", got_q.size(), NBYTES); end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL busy_byte%0d got %h want %h", i, g, e); end
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt - d0); end
        n_tests++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL busy_no_restart got %b want 0", tx_valid); end
        n_tests++; if (got_q.size() != 0)  begin n_fail++; $display("FAIL busy_extra_bytes got %0d want 0", got_q.size()); end
    endtask

    task automatic test_reset_mid_dump();
        bit to;
        int d0;
        set_pattern(0);
        clear_sb();
        d0 = done_cnt;
        tx_ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 100 && got_q.size() < 9; i++) begin
            @(posedge clk); #1;
        end
        n_tests++; if (got_q.size() != 9) begin n_fail++; $display("FAIL mid_pre_count got %0d want 9", got_q.size()); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", tx_valid); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_tests++; if (reg_idx !== 5'd0)  begin n_fail++; $display("FAIL mid_reg_idx got %0d want 0", reg_idx); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (got_q.size() != 9)  begin n_fail++; $display("FAIL mid_no_pending got %0d want 9", got_q.size()); end
        n_tests++; if (done_cnt != d0)     begin n_fail++; $display("FAIL mid_no_done got %0d want 0", done_cnt - d0); end
        clear_sb();
        pulse_start(1'b1);
        n_tests++; if (reg_idx !== 5'd0)  begin n_fail++; $display("FAIL mid_restart_idx got %0d want 0", reg_idx); end
        run_until_done(400, 0, -1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL mid_timeout got timeout want done"); end
        n_tests++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL mid_count got %0d want %0d", got_q.size(), NBYTES); end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", i, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_latency_and_full();
        test_backpressure();
        test_snapshot();
        test_start_while_busy();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
